// File: rtl/lfsr_checker.sv
// Checker for the Fibonacci XNOR LFSR generator: self-synchronises to the incoming
// state words, then flywheels a reference to flag/count word errors and measure period.
module lfsr_checker #(
  parameter int unsigned NUM_BITS = 8,
  parameter logic [NUM_BITS-1:0] TAP_MASK = 8'hB8,
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned UNLOCK_CNT = 4,
  parameter int unsigned ERR_W = 16,
  parameter int unsigned PERIOD_W = 16
) (
  input  logic                i_Clk,
  input  logic                i_Rst,
  input  logic                i_Valid,
  input  logic [NUM_BITS-1:0] i_Data,
  input  logic                i_Clear_Count,
  output logic                o_Locked,
  output logic                o_Err,
  output logic [ERR_W-1:0]    o_Err_Count,
  output logic [PERIOD_W-1:0] o_Period,
  output logic                o_Period_Valid
);

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

  localparam logic [7:0] LOCK_TGT   = 8'(LOCK_CNT);
  localparam logic [7:0] UNLOCK_TGT = 8'(UNLOCK_CNT);

  function automatic logic [NUM_BITS-1:0] lfsr_next(input logic [NUM_BITS-1:0] x);
    return {x[NUM_BITS-2:0], ~(^(x & TAP_MASK))};
  endfunction

  state_t              state_q, state_d;
  logic [NUM_BITS-1:0] prev_q, prev_d;
  logic [NUM_BITS-1:0] exp_q, exp_d;
  logic [NUM_BITS-1:0] ref_q, ref_d;
  logic [7:0]          match_q, match_d;
  logic [7:0]          miss_q, miss_d;
  logic [PERIOD_W-1:0] pcnt_q, pcnt_d, pcnt_inc;
  logic                locked_d, err_d, pvalid_d;
  logic [ERR_W-1:0]    cnt_d;
  logic [PERIOD_W-1:0] period_d;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q        <= HUNT;
      prev_q         <= '0;
      exp_q          <= '0;
      ref_q          <= '0;
      match_q        <= '0;
      miss_q         <= '0;
      pcnt_q         <= '0;
      o_Locked       <= 1'b0;
      o_Err          <= 1'b0;
      o_Err_Count    <= '0;
      o_Period       <= '0;
      o_Period_Valid <= 1'b0;
    end else begin
      state_q        <= state_d;
      prev_q         <= prev_d;
      exp_q          <= exp_d;
      ref_q          <= ref_d;
      match_q        <= match_d;
      miss_q         <= miss_d;
      pcnt_q         <= pcnt_d;
      o_Locked       <= locked_d;
      o_Err          <= err_d;
      o_Err_Count    <= cnt_d;
      o_Period       <= period_d;
      o_Period_Valid <= pvalid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    prev_d   = prev_q;
    exp_d    = exp_q;
    ref_d    = ref_q;
    match_d  = match_q;
    miss_d   = miss_q;
    pcnt_d   = pcnt_q;
    locked_d = o_Locked;
    err_d    = 1'b0;
    cnt_d    = o_Err_Count;
    period_d = o_Period;
    pvalid_d = o_Period_Valid;
    pcnt_inc = (pcnt_q == '1) ? pcnt_q : pcnt_q + PERIOD_W'(1);

    if (i_Valid) begin
      unique case (state_q)
        HUNT: begin
          if (i_Data != '1) begin
            prev_d  = i_Data;
            match_d = '0;
            state_d = VERIFY;
          end
        end
        VERIFY: begin
          prev_d = i_Data;
          if (i_Data == lfsr_next(prev_q) && i_Data != '1) begin
            if (match_q + 8'd1 == LOCK_TGT) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
              exp_d    = lfsr_next(i_Data);
              ref_d    = i_Data;
              pcnt_d   = '0;
              miss_d   = '0;
              match_d  = '0;
            end else begin
              match_d = match_q + 8'd1;
            end
          end else begin
            match_d = '0;
          end
        end
        LOCKED: begin
          // Reference flywheels regardless of input so one bad word costs one error
          exp_d  = lfsr_next(exp_q);
          pcnt_d = pcnt_inc;
          if (i_Data != exp_q) begin
            err_d = 1'b1;
            if (o_Err_Count != '1) cnt_d = o_Err_Count + ERR_W'(1);
            if (miss_q + 8'd1 == UNLOCK_TGT) begin
              state_d  = HUNT;
              locked_d = 1'b0;
              pvalid_d = 1'b0;
              miss_d   = '0;
            end else begin
              miss_d = miss_q + 8'd1;
            end
          end else begin
            miss_d = '0;
            if (i_Data == ref_q) begin
              period_d = pcnt_inc;
              pvalid_d = 1'b1;
              pcnt_d   = '0;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end

    if (i_Clear_Count) cnt_d = '0;
  end

endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker: a behavioural model predicts every output
// after each edge; directed checks cover lock timing, period, errors and reset.
module tb_lfsr_checker;

  localparam int LOCK = 4;
  localparam int UNLOCK = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid = 1'b0;
  logic [7:0]  data = '0;
  logic        clr = 1'b0;
  logic        locked, err, pv;
  logic [15:0] err_cnt, period;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lfsr_checker #(
    .NUM_BITS(8), .TAP_MASK(8'hB8), .LOCK_CNT(LOCK), .UNLOCK_CNT(UNLOCK),
    .ERR_W(16), .PERIOD_W(16)
  ) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Valid(valid), .i_Data(data),
    .i_Clear_Count(clr), .o_Locked(locked), .o_Err(err),
    .o_Err_Count(err_cnt), .o_Period(period), .o_Period_Valid(pv)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // XNOR feedback built bit by bit from the tap list 7,5,4,3
  function automatic logic [7:0] ref_next(input logic [7:0] x);
    logic fb = 1'b1;
    fb = fb ^ x[7] ^ x[5] ^ x[4] ^ x[3];
    return {x[6:0], fb};
  endfunction

  typedef struct {
    logic        locked;
    logic        err;
    logic [15:0] cnt;
    logic [15:0] period;
    logic        pv;
  } exp_t;
  exp_t sb[$];

  int          m_state = 0;
  logic [7:0]  m_prev = '0, m_exp = '0, m_ref = '0;
  int          m_match = 0, m_miss = 0, m_pcnt = 0;
  logic        m_locked = 0, m_err = 0, m_pv = 0;
  logic [15:0] m_cnt = '0, m_period = '0;

  task automatic model(input logic v, input logic [7:0] d, input logic c, input logic r);
    logic hit;
    if (r) begin
      m_state = 0; m_prev = '0; m_exp = '0; m_ref = '0;
      m_match = 0; m_miss = 0; m_pcnt = 0;
      m_locked = 0; m_err = 0; m_pv = 0; m_cnt = '0; m_period = '0;
      return;
    end
    m_err = 0;
    if (v) begin
      if (m_state == 0) begin
        if (d != 8'hFF) begin m_prev = d; m_match = 0; m_state = 1; end
      end else if (m_state == 1) begin
        if (d == ref_next(m_prev) && d != 8'hFF) m_match++;
        else m_match = 0;
        m_prev = d;
        if (m_match == LOCK) begin
          m_state = 2; m_locked = 1; m_exp = ref_next(d); m_ref = d;
          m_pcnt = 0; m_miss = 0; m_match = 0;
        end
      end else begin
        hit = (d == m_exp);
        m_exp = ref_next(m_exp);
        if (m_pcnt < 65535) m_pcnt++;
        if (!hit) begin
          m_err = 1;
          if (m_cnt != 16'hFFFF) m_cnt++;
          m_miss++;
          if (m_miss == UNLOCK) begin m_state = 0; m_locked = 0; m_pv = 0; m_miss = 0; end
        end else begin
          m_miss = 0;
          if (d == m_ref) begin m_period = 16'(m_pcnt); m_pv = 1; m_pcnt = 0; end
        end
      end
    end
    if (c) m_cnt = '0;
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic c, input logic r);
    exp_t e;
    valid = v; data = d; clr = c; rst = r;
    model(v, d, c, r);
    e.locked = m_locked; e.err = m_err; e.cnt = m_cnt; e.period = m_period; e.pv = m_pv;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("sb_locked", 32'(locked), 32'(e.locked));
    check("sb_err", 32'(err), 32'(e.err));
    check("sb_cnt", 32'(err_cnt), 32'(e.cnt));
    check("sb_pv", 32'(pv), 32'(e.pv));
    if (e.pv) check("sb_period", 32'(period), 32'(e.period));
  endtask

  logic [7:0] gen;

  task automatic send_gen(input logic v);
    step(v, gen, 1'b0, 1'b0);
    if (v) gen = ref_next(gen);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_locked"}, 32'(locked), 0);
    check({tag, "_err"}, 32'(err), 0);
    check({tag, "_cnt"}, 32'(err_cnt), 0);
    check({tag, "_period"}, 32'(period), 0);
    check({tag, "_pv"}, 32'(pv), 0);
  endtask

  initial begin
    logic [7:0] w;
    logic       has_zero;

    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check_reset_outputs("reset");

    // Lock from seed F3: 1 load + LOCK matches
    gen = 8'hF3;
    for (int i = 1; i <= 5; i++) begin
      if (i == 2) check("sample2", 32'(gen), 32'hE6);
      send_gen(1'b1);
      check("lock_edge", 32'(locked), (i == 5) ? 1 : 0);
      check("no_err_lock", 32'(err), 0);
    end

    // Two full periods
    for (int p = 0; p < 2; p++) begin
      for (int i = 1; i <= 255; i++) begin
        send_gen(1'b1);
        if (i == 255) begin
          check("period_valid", 32'(pv), 1);
          check("period_val", 32'(period), 255);
        end else if (p == 0) begin
          check("period_early", 32'(pv), 0);
        end
      end
      check("period_errcnt", 32'(err_cnt), 0);
    end

    // Single corrupted word
    step(1'b1, gen ^ 8'h01, 1'b0, 1'b0);
    gen = ref_next(gen);
    check("single_err", 32'(err), 1);
    check("single_cnt", 32'(err_cnt), 1);
    check("single_locked", 32'(locked), 1);
    for (int i = 0; i < 3; i++) begin
      send_gen(1'b1);
      check("after_single", 32'(err), 0);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("clear_cnt", 32'(err_cnt), 0);

    // Error on the same edge as a clear: clear wins
    step(1'b1, gen ^ 8'h10, 1'b1, 1'b0);
    gen = ref_next(gen);
    check("clr_win_err", 32'(err), 1);
    check("clr_win_cnt", 32'(err_cnt), 0);
    send_gen(1'b1);

    // Hold 00 for UNLOCK samples where the expected word is never 00
    has_zero = 1'b1;
    for (int guard = 0; guard < 300 && has_zero; guard++) begin
      w = gen;
      has_zero = 1'b0;
      for (int k = 0; k < 4; k++) begin
        if (w == 8'h00) has_zero = 1'b1;
        w = ref_next(w);
      end
      if (has_zero) send_gen(1'b1);
    end
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 8'h00, 1'b0, 1'b0);
      gen = ref_next(gen);
      check("zero_err", 32'(err), 1);
      check("zero_locked", 32'(locked), (i == 4) ? 0 : 1);
    end
    check("zero_cnt", 32'(err_cnt), 4);
    check("zero_pv", 32'(pv), 0);
    for (int i = 1; i <= 5; i++) begin
      send_gen(1'b1);
      check("relock", 32'(locked), (i == 5) ? 1 : 0);
    end

    // All-ones lock-up word never locks
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 8'hFF, 1'b0, 1'b0);
      check("ff_locked", 32'(locked), 0);
      check("ff_err", 32'(err), 0);
    end

    // Gapped valid: lock index and period are in accepted samples
    step(1'b0, 8'h00, 1'b0, 1'b1);
    gen = 8'hF3;
    for (int i = 1; i <= 5; i++) begin
      send_gen(1'b1);
      check("gap_lock", 32'(locked), (i == 5) ? 1 : 0);
      send_gen(1'b0);
    end
    for (int i = 1; i <= 255; i++) begin
      send_gen(1'b1);
      send_gen(1'b0);
    end
    check("gap_pv", 32'(pv), 1);
    check("gap_period", 32'(period), 255);

    // Reset while locked, then relock from fresh samples
    step(1'b1, gen, 1'b0, 1'b1);
    check_reset_outputs("midrst");
    for (int i = 1; i <= 5; i++) begin
      send_gen(1'b1);
      check("rst_relock", 32'(locked), (i == 5) ? 1 : 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
